// File: rtl/mm2s_run_scheduler_if.sv
// mm2s_run_scheduler_if
//   Bundles the scheduler's configuration, run-control, status and
//   mm2s-engine signals.
//
//   Handshake rules:
//     - A descriptor write happens on any clock edge where cfg_valid and
//       cfg_ready are both high.
//     - run_req and abort are single-cycle strobes. They are not held.
//     - start is a one-cycle pulse to the engine. core_ready is the
//       engine's registered idle flag.
//
//   Modports:
//     slave  : the scheduler itself.
//     master : everything around it (the control registers and the mm2s
//              engine).
interface mm2s_run_scheduler_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int N_CHANNELS = 16,
  parameter int CNT_WIDTH  = 32
);
  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [3:0]                           cfg_ch;
  logic [ADDR_WIDTH-1:0]                cfg_addr;
  logic [ADDR_WIDTH-1:0]                cfg_size;
  logic                                 run_req;
  logic [CNT_WIDTH-1:0]                 run_loops;
  logic                                 abort;
  logic                                 busy;
  logic                                 done;
  logic [CNT_WIDTH-1:0]                 loops_done;
  logic [CNT_WIDTH-1:0]                 run_cycles;
  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_size;
  logic                                 start;
  logic                                 core_ready;

  modport slave (
    input  cfg_valid, cfg_ch, cfg_addr, cfg_size,
    input  run_req, run_loops, abort, core_ready,
    output cfg_ready, busy, done, loops_done, run_cycles,
    output rd_addr, rd_size, start
  );

  modport master (
    output cfg_valid, cfg_ch, cfg_addr, cfg_size,
    output run_req, run_loops, abort, core_ready,
    input  cfg_ready, busy, done, loops_done, run_cycles,
    input  rd_addr, rd_size, start
  );
endinterface

// File: rtl/mm2s_run_scheduler.sv
// mm2s_run_scheduler
//   Holds the per-channel read descriptors for the mm2s engine. It launches
//   the engine, waits for the engine to drain, and repeats the run
//   run_loops times. A run_loops value of 0 repeats the run until abort.
//   Completed iterations and elapsed cycles are reported while the sequence
//   runs, and a done pulse marks the end of a sequence.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : mm2s_run_scheduler_if.slave. It carries the config port,
//              run control, status, the descriptors and start/core_ready.
//   o_state  : current FSM state, for debug visibility.
module mm2s_run_scheduler #(
  parameter int ADDR_WIDTH = 64,
  parameter int N_CHANNELS = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mm2s_run_scheduler_if.slave   bus,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                                r_state;
  state_t                                w_next;
  logic [CNT_WIDTH-1:0]                  r_loops_target;
  logic [CNT_WIDTH-1:0]                  r_loops_done;
  logic [CNT_WIDTH-1:0]                  r_run_cycles;
  logic [CNT_WIDTH-1:0]                  w_loops_inc;
  logic                                  r_abort_pending;
  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0] r_rd_addr;
  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0] r_rd_size;
  logic                                  w_cfg_fire;
  logic                                  w_launch;
  logic                                  w_iter_done;
  logic                                  w_last_iter;

  assign w_cfg_fire  = bus.cfg_valid && (r_state == S_IDLE);
  // A run request is dropped, not queued, while the engine is still busy.
  assign w_launch    = (r_state == S_IDLE) && bus.run_req && bus.core_ready;
  assign w_iter_done = (r_state == S_WAIT_DONE) && bus.core_ready;
  assign w_loops_inc = r_loops_done + CNT_ONE;
  // An abort that arrives in the same cycle as the drain still ends the
  // sequence after this iteration. A target of 0 means "run until abort".
  // When the target is nonzero, loops_done stays below it, so w_loops_inc
  // cannot wrap here.
  assign w_last_iter = r_abort_pending || bus.abort ||
                       ((r_loops_target != '0) && (w_loops_inc == r_loops_target));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_launch) w_next = S_LAUNCH;
      S_LAUNCH:    w_next = S_WAIT_ACK;
      // One guard cycle, so that the engine's registered core_ready has
      // fallen before it is watched.
      S_WAIT_ACK:  w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.core_ready) w_next = w_last_iter ? S_FINISH : S_LAUNCH;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.start      = (r_state == S_LAUNCH);
    bus.done       = (r_state == S_FINISH);
    bus.busy       = (r_state != S_IDLE);
    bus.cfg_ready  = (r_state == S_IDLE);
    bus.loops_done = r_loops_done;
    bus.run_cycles = r_run_cycles;
    bus.rd_addr    = r_rd_addr;
    bus.rd_size    = r_rd_size;
    o_state        = r_state;
  end

  // Descriptors and sequence counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr       <= '0;
      r_rd_size       <= '0;
      r_loops_target  <= '0;
      r_loops_done    <= '0;
      r_run_cycles    <= '0;
      r_abort_pending <= 1'b0;
    end else begin
      // A write to a channel index that does not exist is accepted and
      // then matches no channel.
      if (w_cfg_fire) begin
        for (int c = 0; c < N_CHANNELS; c++) begin
          if (bus.cfg_ch == 4'(c)) begin
            r_rd_addr[c] <= bus.cfg_addr;
            r_rd_size[c] <= bus.cfg_size;
          end
        end
      end
      if (w_launch) begin
        r_loops_target  <= bus.run_loops;
        r_loops_done    <= '0;
        r_run_cycles    <= '0;
        r_abort_pending <= 1'b0;
      end else begin
        if (r_state != S_IDLE) begin
          if (bus.abort) r_abort_pending <= 1'b1;
          if (r_run_cycles != CNT_MAX) r_run_cycles <= r_run_cycles + CNT_ONE;
        end
        if (w_iter_done && (r_loops_done != CNT_MAX)) r_loops_done <= w_loops_inc;
      end
    end
  end

endmodule

// File: doc/mm2s_run_scheduler.md
Name: mm2s_run_scheduler

Overview:
Sequences the multi-channel mm2s read engine. It holds per-channel read descriptors (address and size) written through a config port, and pulses the engine start. It waits for the engine to drain, then repeats the run a programmed number of times or until aborted. It also reports loop count, elapsed cycles and a done pulse to the traffic-engine control registers.

Parameters:
ADDR_WIDTH, 64, width of descriptor address/size (bytes)
N_CHANNELS, 16, number of mm2s channels (1..16)
CNT_WIDTH, 32, width of loop and cycle counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_valid  in  1  descriptor write strobe
cfg_ready  out  1  descriptor write accepted (high only in IDLE)
cfg_ch  in  4  target channel index
cfg_addr  in  ADDR_WIDTH  channel start byte address
cfg_size  in  ADDR_WIDTH  channel byte count
run_req  in  1  single-cycle run request
run_loops  in  CNT_WIDTH  iterations; 0 = run until abort
abort  in  1  single-cycle stop request
busy  out  1  high outside IDLE
done  out  1  single-cycle pulse when sequence ends
loops_done  out  CNT_WIDTH  completed iterations of current/last sequence
run_cycles  out  CNT_WIDTH  cycles since sequence launch, saturating
rd_addr  out  ADDR_WIDTH x N_CHANNELS  to mm2s
rd_size  out  ADDR_WIDTH x N_CHANNELS  to mm2s
start  out  1  to mm2s, single-cycle pulse
core_ready  in  1  from mm2s; registered, falls the cycle after start

Behaviour:
- Reset values: all rd_addr/rd_size 0, start 0, done 0, busy 0, loops_done 0, run_cycles 0, cfg_ready 1, FSM in IDLE. Reset mid-run returns to IDLE immediately and clears all descriptors. The mm2s engine is reset by the same rst.
- Config: write when cfg_valid && cfg_ready. The write updates rd_addr[cfg_ch] and rd_size[cfg_ch] on the next edge. If cfg_ch >= N_CHANNELS, the write is accepted and discarded. Descriptors persist across runs.
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE: run_req && core_ready moves to LAUNCH. The edge that does this also latches run_loops, clears loops_done and run_cycles, and clears abort_pending.
  - run_req while core_ready=0 is dropped; it is not queued.
  - A config write and run_req in the same cycle are both taken, and the run uses the new descriptor.
- LAUNCH: start=1 for exactly this cycle, then go to WAIT_ACK.
- WAIT_ACK: one guard cycle, covering the registered core_ready fall, then go to WAIT_DONE unconditionally.
- WAIT_DONE: on core_ready=1, increment loops_done.
  - If abort_pending, or run_loops latched != 0 and loops_done+1 == run_loops latched, go to FINISH.
  - Otherwise go to LAUNCH, which restarts with the same descriptors. The gap between core_ready rising and the next start is 1 cycle.
- FINISH: done=1 for this cycle, then go to IDLE.
- abort: sampled in any non-IDLE state and sets abort_pending. abort in IDLE is ignored. The in-flight iteration always completes, because mm2s has no cancel. abort in the same cycle as core_ready rises in WAIT_DONE ends the sequence after that iteration.
- run_cycles increments every cycle from LAUNCH entry through the FINISH cycle inclusive, saturates at all-ones, and holds its value in IDLE.
- loops_done wraps never: it saturates at all-ones in infinite mode.
- busy = (state != IDLE). cfg_ready = (state == IDLE).
- All-zero descriptors are legal. mm2s returns core_ready within 2 cycles, so each iteration is still counted.

Test Plan:
- Write ch0 addr 0x1000 size 0x2000 and ch3 addr 0x8000 size 0x40, run_loops=1, run_req. Required: one start pulse; rd_addr[3]=0x8000 at start; done one cycle after core_ready rises; loops_done=1.
- run_loops=3 with the same descriptors. Required: exactly 3 start pulses, each 1 cycle after core_ready rises; done after the third; loops_done=3; busy high throughout.
- run_loops=0, with abort asserted during the 5th iteration's WAIT_DONE. Required: 5th iteration completes, no 6th start, done pulses, loops_done=5.
- run_req while core_ready=0 from a prior external start. Required: no start and busy stays 0. A later run_req with core_ready=1 launches.
- cfg_valid during WAIT_DONE. Required: cfg_ready=0 and descriptors unchanged. cfg_ch=15 with N_CHANNELS=4 in IDLE is accepted with no register change.
- rst asserted in WAIT_DONE of loop 2 of 4. Required: next cycle state IDLE, busy 0, all rd_size 0, no done pulse, no further start.
